dic_tx_sched: RTL

UART transmit scheduler for the digital clock. Shares the single UART transmitter between three requesters: key echo, alarm message and the once-per-second time report. It serialises each as whole ASCII frames over a start/busy handshake. It sits between the clock datapath/`dictrl` outputs and the UART TX module.

---
 rtl/dic_tx_sched_if.sv | 9 +
 rtl/dic_tx_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dic_tx_sched_if.sv
// Start/busy handshake between the transmit scheduler (master) and the UART transmitter (slave).
interface dic_tx_sched_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/dic_tx_sched.sv
// dic_tx_sched: shares one UART transmitter between key echo, alarm message and time report frames.
// Define DIC_TX_ALARM_EN to compile in the ALARM frame and its request latch.
module dic_tx_sched #(
    parameter bit TIME_TX = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sec_strobe,
    input  logic [3:0]     Mtens,
    input  logic [3:0]     Mones,
    input  logic [3:0]     Stens,
    input  logic [3:0]     Sones,
    input  logic           alarm_hit,
    input  logic           echo_req,
    input  logic [7:0]     echo_data,
    dic_tx_sched_if.master tx,
    output logic           frame_busy,
    output logic           echo_ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    localparam logic [1:0] FT_ECHO  = 2'd0;
`ifdef DIC_TX_ALARM_EN
    localparam logic [1:0] FT_ALARM = 2'd1;
`endif
    localparam logic [1:0] FT_TIME  = 2'd2;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        if (d <= 4'd9) begin
            return 8'h30 + {4'h0, d};
        end else begin
            return 8'h3F;
        end
    endfunction

    function automatic logic [7:0] frame_byte(input logic [1:0] ftype, input logic [2:0] idx,
                                              input logic [15:0] fbuf);
        logic [7:0] b;
        case (ftype)
            FT_ECHO: b = fbuf[7:0];
`ifdef DIC_TX_ALARM_EN
            FT_ALARM: begin
                case (idx)
                    3'd0:    b = 8'h41;
                    3'd1:    b = 8'h4C;
                    3'd2:    b = 8'h41;
                    3'd3:    b = 8'h52;
                    3'd4:    b = 8'h4D;
                    3'd5:    b = 8'h0D;
                    default: b = 8'h0A;
                endcase
            end
`endif
            FT_TIME: begin
                case (idx)
                    3'd0:    b = digit_ascii(fbuf[15:12]);
                    3'd1:    b = digit_ascii(fbuf[11:8]);
                    3'd2:    b = 8'h3A;
                    3'd3:    b = digit_ascii(fbuf[7:4]);
                    3'd4:    b = digit_ascii(fbuf[3:0]);
                    3'd5:    b = 8'h0D;
                    default: b = 8'h0A;
                endcase
            end
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [2:0] last_idx(input logic [1:0] ftype);
        if (ftype == FT_ECHO) begin
            return 3'd0;
        end else begin
            return 3'd6;
        end
    endfunction

    logic [1:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  ftype_q, ftype_d;
    logic [15:0] fbuf_q, fbuf_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        frame_busy_q, frame_busy_d;
    logic        echo_pend_q, echo_pend_d;
    logic [7:0]  echo_byte_q, echo_byte_d;
    logic        echo_ovf_q, echo_ovf_d;
    logic        time_pend_q, time_pend_d;
    logic [15:0] snap_q, snap_d;
    logic        start_echo_s, start_time_s;
    logic        alarm_pend_s;
    logic        any_pend_s;

`ifdef DIC_TX_ALARM_EN
    logic        alarm_pend_q, alarm_pend_d;
    logic        start_alarm_s;
    assign alarm_pend_s = alarm_pend_q;
`else
    logic        unused_alarm_s;
    assign alarm_pend_s   = 1'b0;
    assign unused_alarm_s = alarm_hit;
`endif

    assign any_pend_s = echo_pend_q | alarm_pend_s | time_pend_q;

    // Frame sequencer: arbitration in IDLE, then SEND/HOLD/WAIT per byte
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ftype_d      = ftype_q;
        fbuf_d       = fbuf_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        start_echo_s = 1'b0;
        start_time_s = 1'b0;
`ifdef DIC_TX_ALARM_EN
        start_alarm_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_pend_s) begin
                    state_d    = ST_SEND;
                    idx_d      = 3'd0;
                    tx_start_d = 1'b1;
                    if (echo_pend_q) begin
                        ftype_d      = FT_ECHO;
                        fbuf_d       = {8'h00, echo_byte_q};
                        start_echo_s = 1'b1;
`ifdef DIC_TX_ALARM_EN
                    end else if (alarm_pend_s) begin
                        ftype_d       = FT_ALARM;
                        fbuf_d        = 16'h0000;
                        start_alarm_s = 1'b1;
`endif
                    end else begin
                        // Frame copy decouples the in-flight bytes from later snapshot updates
                        ftype_d      = FT_TIME;
                        fbuf_d       = snap_q;
                        start_time_s = 1'b1;
                    end
                    tx_data_d = frame_byte(ftype_d, 3'd0, fbuf_d);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: state_d = ST_HOLD;
            ST_HOLD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx.tx_busy) begin
                    state_d = ST_WAIT;
                end else if (idx_q == last_idx(ftype_q)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_SEND;
                    idx_d      = idx_q + 3'd1;
                    tx_start_d = 1'b1;
                    tx_data_d  = frame_byte(ftype_q, idx_q + 3'd1, fbuf_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        frame_busy_d = (state_d != ST_IDLE);
    end

    // Request latches; a pulse coinciding with its own frame start becomes a fresh request
    always_comb begin
        echo_pend_d = (echo_pend_q & ~start_echo_s) | echo_req;
        if (echo_req && (!echo_pend_q || start_echo_s)) begin
            echo_byte_d = echo_data;
        end else begin
            echo_byte_d = echo_byte_q;
        end
        echo_ovf_d  = echo_ovf_q | (echo_req & echo_pend_q & ~start_echo_s);
        time_pend_d = (time_pend_q & ~start_time_s) | (sec_strobe & TIME_TX);
        if (sec_strobe) begin
            snap_d = {Mtens, Mones, Stens, Sones};
        end else begin
            snap_d = snap_q;
        end
`ifdef DIC_TX_ALARM_EN
        alarm_pend_d = (alarm_pend_q & ~start_alarm_s) | alarm_hit;
`endif
    end

    // State, request and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            ftype_q      <= FT_ECHO;
            fbuf_q       <= 16'h0000;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            frame_busy_q <= 1'b0;
            echo_pend_q  <= 1'b0;
            echo_byte_q  <= 8'h00;
            echo_ovf_q   <= 1'b0;
            time_pend_q  <= 1'b0;
            snap_q       <= 16'h0000;
`ifdef DIC_TX_ALARM_EN
            alarm_pend_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ftype_q      <= ftype_d;
            fbuf_q       <= fbuf_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            frame_busy_q <= frame_busy_d;
            echo_pend_q  <= echo_pend_d;
            echo_byte_q  <= echo_byte_d;
            echo_ovf_q   <= echo_ovf_d;
            time_pend_q  <= time_pend_d;
            snap_q       <= snap_d;
`ifdef DIC_TX_ALARM_EN
            alarm_pend_q <= alarm_pend_d;
`endif
        end
    end

    assign tx.tx_start = tx_start_q;
    assign tx.tx_data  = tx_data_q;
    assign frame_busy  = frame_busy_q;
    assign echo_ovf    = echo_ovf_q;

endmodule
